// File: rtl/alu_sequencer.sv
// Multi-cycle register-to-register ALU sequencer: READ -> EXEC|MUL -> WB.
// Optional macro ALU_MUL_EN adds the MUL state and shift-add multiplier for op 8.
module alu_sequencer #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic [SEL_W-1:0]  A_sel,
  output logic [SEL_W-1:0]  B_sel,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] replaceData,
  output logic [SEL_W-1:0]  replaceSel,
  output logic              replaceEn,
  output logic              carry,
  output logic              zero,
  output logic              done
);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                         OP_XOR = 4'd4, OP_SHL = 4'd5, OP_SHR = 4'd6, OP_MOV = 4'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_EXEC,
`ifdef ALU_MUL_EN
    S_MUL,
`endif
    S_WB
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [SEL_W-1:0]    dst_q, dst_d, a_sel_q, a_sel_d, b_sel_q, b_sel_d, rep_sel_q, rep_sel_d;
  logic [DATA_W-1:0]   opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic                rep_en_q, rep_en_d, done_q, done_d, ready_q, ready_d;
  logic                carry_q, carry_d, zero_q, zero_d, cpend_q, cpend_d;
  logic [DATA_W:0]     ext;
  logic [DATA_W-1:0]   alu_r;
  logic                alu_c, alu_wr;

`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [3:0] OP_MUL = 4'd8;
  logic [2*DATA_W-1:0] prod_q, prod_d, prod_n;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W:0]     msum;
`endif

  // Single-cycle ALU on the captured operands; alu_wr=0 marks a NOP
  always_comb begin
    ext    = '0;
    alu_r  = '0;
    alu_c  = 1'b0;
    alu_wr = 1'b1;
    case (op_q)
      OP_ADD: begin ext = {1'b0, opa_q} + {1'b0, opb_q}; alu_r = ext[DATA_W-1:0]; alu_c = ext[DATA_W]; end
      OP_SUB: begin ext = {1'b0, opa_q} - {1'b0, opb_q}; alu_r = ext[DATA_W-1:0]; alu_c = ext[DATA_W]; end
      OP_AND: alu_r = opa_q & opb_q;
      OP_OR:  alu_r = opa_q | opb_q;
      OP_XOR: alu_r = opa_q ^ opb_q;
      OP_SHL: begin alu_r = opa_q << 1; alu_c = opa_q[DATA_W-1]; end
      OP_SHR: begin alu_r = opa_q >> 1; alu_c = opa_q[0]; end
      OP_MOV: alu_r = opa_q;
      default: alu_wr = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    dst_d     = dst_q;
    a_sel_d   = a_sel_q;
    b_sel_d   = b_sel_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
    rep_sel_d = rep_sel_q;
    cpend_d   = cpend_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    ready_d   = ready_q;
    rep_en_d  = 1'b0;
    done_d    = 1'b0;
`ifdef ALU_MUL_EN
    prod_d = prod_q;
    cnt_d  = cnt_q;
    // Shift-add step: add multiplicand into the high half when LSB set, then shift right
    msum   = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + (prod_q[0] ? {1'b0, opa_q} : '0);
    prod_n = {msum, prod_q[DATA_W-1:1]};
`endif
    case (state_q)
      S_IDLE: if (instr_valid && ready_q) begin
        op_d    = instr[15:12];
        dst_d   = instr[8 +: SEL_W];
        a_sel_d = instr[4 +: SEL_W];
        b_sel_d = instr[0 +: SEL_W];
        ready_d = 1'b0;
        state_d = S_READ;
      end
      S_READ: begin
        opa_d   = A;
        opb_d   = B;
        state_d = S_EXEC;
`ifdef ALU_MUL_EN
        if (op_q == OP_MUL) begin
          prod_d  = {{DATA_W{1'b0}}, B};
          cnt_d   = '0;
          state_d = S_MUL;
        end
`endif
      end
      S_EXEC: begin
        rep_en_d  = alu_wr;
        done_d    = 1'b1;
        rep_sel_d = dst_q;
        if (alu_wr) begin
          res_d   = alu_r;
          cpend_d = alu_c;
        end
        state_d = S_WB;
      end
`ifdef ALU_MUL_EN
      S_MUL: begin
        prod_d = prod_n;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          res_d     = prod_n[DATA_W-1:0];
          cpend_d   = |prod_n[2*DATA_W-1:DATA_W];
          rep_en_d  = 1'b1;
          done_d    = 1'b1;
          rep_sel_d = dst_q;
          state_d   = S_WB;
        end
      end
`endif
      S_WB: begin
        // Flags trail the write strobe by one cycle and only move for writing ops
        if (rep_en_q) begin
          carry_d = cpend_q;
          zero_d  = (res_q == '0);
        end
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      dst_q     <= '0;
      a_sel_q   <= '0;
      b_sel_q   <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      res_q     <= '0;
      rep_sel_q <= '0;
      cpend_q   <= 1'b0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      ready_q   <= 1'b1;
      rep_en_q  <= 1'b0;
      done_q    <= 1'b0;
`ifdef ALU_MUL_EN
      prod_q    <= '0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      dst_q     <= dst_d;
      a_sel_q   <= a_sel_d;
      b_sel_q   <= b_sel_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      res_q     <= res_d;
      rep_sel_q <= rep_sel_d;
      cpend_q   <= cpend_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      ready_q   <= ready_d;
      rep_en_q  <= rep_en_d;
      done_q    <= done_d;
`ifdef ALU_MUL_EN
      prod_q    <= prod_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign instr_ready = ready_q;
  assign A_sel       = a_sel_q;
  assign B_sel       = b_sel_q;
  assign replaceData = res_q;
  assign replaceSel  = rep_sel_q;
  assign replaceEn   = rep_en_q;
  assign carry       = carry_q;
  assign zero        = zero_q;
  assign done        = done_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: register-file model plus arithmetic reference for each op.
module tb_alu_sequencer;
  localparam int DW = 8;
  localparam int SW = 4;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic          clk = 1'b0, rst = 1'b1, instr_valid = 1'b0;
  logic [15:0]   instr = '0;
  logic          instr_ready, replaceEn, carry, zero, done;
  logic [SW-1:0] A_sel, B_sel, replaceSel;
  logic [DW-1:0] A, B, replaceData;

  alu_sequencer #(.DATA_W(DW), .SEL_W(SW)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .A_sel(A_sel), .B_sel(B_sel), .A(A), .B(B), .replaceData(replaceData),
    .replaceSel(replaceSel), .replaceEn(replaceEn), .carry(carry), .zero(zero), .done(done)
  );

  always #5 clk = ~clk;

  // Register file model: combinational read, write on replaceEn or bench setup
  logic [DW-1:0] rf [16];
  logic          set_en = 1'b0;
  logic [3:0]    set_idx = '0;
  logic [DW-1:0] set_val = '0;
  always @(posedge clk) begin
    if (set_en) rf[set_idx] <= set_val;
    else if (replaceEn) rf[replaceSel] <= replaceData;
  end
  assign A = rf[A_sel];
  assign B = rf[B_sel];

  int errs = 0, checks = 0;
  bit carry_m = 1'b0, zero_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_reg(input int idx, input int val);
    set_en = 1'b1; set_idx = 4'(idx); set_val = 8'(val);
    @(negedge clk);
    set_en = 1'b0;
  endtask

  // Issue one instruction from idle and check the whole transaction against the reference
  task automatic run(input logic [15:0] iw, input bit hold, input logic [15:0] nxt);
    logic [3:0] op, dst, sa, sb;
    logic [7:0] old_dst;
    int a, b, res, c, exp_wb, cyc, en_cnt;
    bit wr, got;
    {op, dst, sa, sb} = iw;
    a = int'(rf[sa]); b = int'(rf[sb]); old_dst = rf[dst];
    wr = 1'b1; c = 0; res = 0; exp_wb = 3;
    case (op)
      0: begin res = a + b; c = (res > 255) ? 1 : 0; end
      1: begin res = a - b; c = (a < b) ? 1 : 0; end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: begin res = a * 2; c = (a >= 128) ? 1 : 0; end
      6: begin res = a / 2; c = a % 2; end
      7: res = a;
      8: if (MUL_EN) begin res = a * b; c = (res > 255) ? 1 : 0; exp_wb = 2 + DW; end
         else wr = 1'b0;
      default: wr = 1'b0;
    endcase
    res = res & 255;

    instr = iw; instr_valid = 1'b1;
    chk("ready_idle", instr_ready, 1);
    @(posedge clk);
    @(negedge clk);
    if (hold) instr = nxt; else instr_valid = 1'b0;
    cyc = 1; en_cnt = 0; got = 1'b0;
    chk("a_sel", A_sel, sa);
    chk("b_sel", B_sel, sb);
    chk("busy_ready", instr_ready, 0);
    while (!got && cyc <= 40) begin
      if (replaceEn) en_cnt++;
      if (done) got = 1'b1;
      else begin @(negedge clk); cyc++; end
    end
    chk("done_seen", got, 1);
    chk("wb_cycle", cyc, exp_wb);
    chk("wb_en", replaceEn, wr);
    chk("en_count", en_cnt, wr);
    if (wr) begin
      chk("wb_sel", replaceSel, dst);
      chk("wb_data", replaceData, res);
      carry_m = (c != 0);
      zero_m  = (res == 0);
    end
    @(negedge clk);
    chk("carry", carry, carry_m);
    chk("zero", zero, zero_m);
    chk("ready_after", instr_ready, 1);
    chk("done_clear", done, 0);
    chk("en_clear", replaceEn, 0);
    chk("rf_dst", rf[dst], wr ? res : int'(old_dst));
  endtask

  logic [15:0] q [30];
  int  cyc, rst_cyc;
  bit  en_seen, hold;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 16; i++) set_reg(i, int'($urandom_range(0, 255)));
    chk("rst_ready", instr_ready, 1);
    chk("rst_asel", A_sel, 0);
    chk("rst_bsel", B_sel, 0);
    chk("rst_data", replaceData, 0);
    chk("rst_sel", replaceSel, 0);
    chk("rst_en", replaceEn, 0);
    chk("rst_carry", carry, 0);
    chk("rst_zero", zero, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed: ADD without and with carry, SUB with borrow
    set_reg(1, 8'h0F); set_reg(2, 8'h01);
    run({4'h0, 4'h3, 4'h1, 4'h2}, 1'b0, '0);
    set_reg(1, 8'hFF);
    run({4'h0, 4'h4, 4'h1, 4'h2}, 1'b0, '0);
    run({4'h1, 4'h5, 4'h2, 4'h1}, 1'b0, '0);
    // MUL (or NOP when the multiplier is absent), dst aliasing srcA
    set_reg(6, 8'h0C); set_reg(7, 8'h0B);
    run({4'h8, 4'h6, 4'h6, 4'h7}, 1'b0, '0);
    // NOP keeps flags, SHR of 1 sets carry and zero
    run({4'hF, 4'h2, 4'h1, 4'h2}, 1'b0, '0);
    set_reg(8, 8'h01);
    run({4'h6, 4'h9, 4'h8, 4'h0}, 1'b0, '0);

    // Reset in the middle of an instruction
    set_reg(6, 8'h0C);
    rst_cyc = MUL_EN ? 5 : 2;
    instr = {4'h8, 4'h6, 4'h6, 4'h7}; instr_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    instr_valid = 1'b0; cyc = 1;
    while (cyc < rst_cyc) begin @(negedge clk); cyc++; end
    rst = 1'b1;
    #1;
    chk("mid_rst_en", replaceEn, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ready", instr_ready, 1);
    chk("mid_rst_carry", carry, 0);
    chk("mid_rst_zero", zero, 0);
    carry_m = 1'b0; zero_m = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    en_seen = 1'b0;
    repeat (16) begin @(negedge clk); if (replaceEn) en_seen = 1'b1; end
    chk("mid_rst_no_wb", en_seen, 0);
    chk("mid_rst_ready2", instr_ready, 1);
    chk("mid_rst_r6", rf[6], 8'h0C);

    // Two instructions back to back with instr_valid held through the busy period
    set_reg(1, 8'h35); set_reg(2, 8'h47);
    run({4'h0, 4'hA, 4'h1, 4'h2}, 1'b1, {4'h1, 4'hB, 4'hA, 4'h2});
    run({4'h1, 4'hB, 4'hA, 4'h2}, 1'b0, '0);

    // Random instruction stream, sometimes presented while the previous one is busy
    for (int i = 0; i < 30; i++) q[i] = 16'($urandom);
    for (int i = 0; i < 30; i++) begin
      hold = (i < 29) && ($urandom_range(0, 1) == 1);
      run(q[i], hold, q[(i < 29) ? i + 1 : i]);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1, "watchdog");
  end
endmodule
